// File: rtl/if_id_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and the IF/ID register.
package if_id_stage_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_id_stage.sv
// Instruction fetch plus IF/ID register with a one-entry skid buffer,
// hazard stall, and redirect handling for in-flight fetches.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_id,
  output logic [31:0] ID_npc,
  output logic        ID_valid
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pending_pc;
  logic [31:0] skid;
  logic [31:0] pc_plus4;

  assign pc_plus4  = pc + 32'd4;
  // HOLD already owns the word at pc, so no request is issued there.
  assign imem_req  = !rst && (state != HOLD);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      pending_pc <= 32'h0;
      skid       <= 32'h0;
      inst_id    <= NOP_INST;
      ID_npc     <= 32'h0;
      ID_valid   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect) begin
            inst_id  <= NOP_INST;
            ID_npc   <= 32'h0;
            ID_valid <= 1'b0;
            skid     <= 32'h0;
            if (imem_ready) begin
              pc <= redirect_pc;
            end else begin
              // The outstanding request must finish at the old address.
              pending_pc <= redirect_pc;
              state      <= DISCARD;
            end
          end else if (imem_ready) begin
            if (!stall) begin
              inst_id  <= imem_rdata;
              ID_npc   <= pc_plus4;
              ID_valid <= 1'b1;
              pc       <= pc_plus4;
            end else begin
              skid  <= imem_rdata;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            inst_id  <= NOP_INST;
            ID_npc   <= 32'h0;
            ID_valid <= 1'b0;
            skid     <= 32'h0;
            pc       <= redirect_pc;
            state    <= FETCH;
          end else if (!stall) begin
            inst_id  <= skid;
            ID_npc   <= pc_plus4;
            ID_valid <= 1'b1;
            pc       <= pc_plus4;
            state    <= FETCH;
          end
        end
        DISCARD: begin
          inst_id  <= NOP_INST;
          ID_npc   <= 32'h0;
          ID_valid <= 1'b0;
          if (redirect) pending_pc <= redirect_pc;
          if (imem_ready) begin
            pc    <= redirect ? redirect_pc : pending_pc;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboarded bench for if_id_stage: streaming, stall/skid, redirects, wrap, reset.
module tb_if_id_stage;
  import if_id_stage_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_ready = 1'b0;
  logic        imem_req, w_imem_req;
  logic [31:0] imem_addr, imem_rdata, inst_id, ID_npc;
  logic [31:0] w_imem_addr, w_imem_rdata, w_inst_id, w_ID_npc;
  logic        ID_valid, w_ID_valid;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] npc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_pc = 32'h0;

  assign imem_rdata   = imem_addr ^ KEY;
  assign w_imem_rdata = w_imem_addr ^ KEY;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .inst_id(inst_id), .ID_npc(ID_npc), .ID_valid(ID_valid)
  );

  if_id_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(imem_ready),
    .imem_rdata(w_imem_rdata), .inst_id(w_inst_id), .ID_npc(w_ID_npc), .ID_valid(w_ID_valid)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  // Record the word the bench expects to land in IF/ID when exp_pc is accepted.
  task automatic push_fetch();
    exp_t x;
    x.inst = word(exp_pc);
    x.npc  = exp_pc + 32'd4;
    exp_q.push_back(x);
    exp_pc = exp_pc + 32'd4;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ready = 1'b1;
    tick();
    checks++;
    if ({ID_valid, inst_id, ID_npc, imem_req} !== {1'b0, 32'h0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs actual v=%b i=%h n=%h req=%b required v=0 i=0 n=0 req=0",
               ID_valid, inst_id, ID_npc, imem_req);
    end
    checks++;
    if ({imem_addr, w_imem_addr} !== {32'h0, 32'hFFFF_FFFC}) begin
      failures++;
      $display("FAIL reset_pc actual=%h/%h required=00000000/fffffffc", imem_addr, w_imem_addr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL first_req actual req=%b addr=%h required req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    exp_pc = 32'h0;
    for (int k = 0; k < 3; k++) begin
      push_fetch();
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({ID_valid, inst_id, ID_npc} !== {1'b1, e.inst, e.npc}) begin
        failures++;
        $display("FAIL stream_%0d actual v=%b i=%h n=%h required v=1 i=%h n=%h",
                 k, ID_valid, inst_id, ID_npc, e.inst, e.npc);
      end
      checks++;
      if (imem_addr !== exp_pc) begin
        failures++;
        $display("FAIL stream_addr_%0d actual=%h required=%h", k, imem_addr, exp_pc);
      end
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1; imem_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({w_ID_valid, w_inst_id, w_ID_npc, w_imem_addr} !== {1'b1, word(32'hFFFF_FFFC), 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL wrap_first actual v=%b i=%h n=%h a=%h required v=1 i=%h n=0 a=0",
               w_ID_valid, w_inst_id, w_ID_npc, w_imem_addr, word(32'hFFFF_FFFC));
    end
    tick();
    checks++;
    if ({w_inst_id, w_ID_npc, w_imem_addr} !== {word(32'h0), 32'h4, 32'h4}) begin
      failures++;
      $display("FAIL wrap_second actual i=%h n=%h a=%h required i=%h n=4 a=4",
               w_inst_id, w_ID_npc, w_imem_addr, word(32'h0));
    end
    // Main instance has now consumed the words at 0 and 4.
    exp_pc = 32'h8;
    exp_q.delete();
  endtask

  task automatic test_stall();
    stall = 1'b1; imem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({ID_valid, inst_id, ID_npc, imem_req} !== {1'b1, word(32'h4), 32'h8, 1'b0}) begin
        failures++;
        $display("FAIL stall_hold_%0d actual v=%b i=%h n=%h req=%b required v=1 i=%h n=8 req=0",
                 k, ID_valid, inst_id, ID_npc, imem_req, word(32'h4));
      end
    end
    stall = 1'b0;
    for (int k = 0; k < 2; k++) begin
      push_fetch();
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({ID_valid, inst_id, ID_npc, imem_req, imem_addr} !== {1'b1, e.inst, e.npc, 1'b1, exp_pc}) begin
        failures++;
        $display("FAIL stall_release_%0d actual v=%b i=%h n=%h req=%b a=%h required v=1 i=%h n=%h req=1 a=%h",
                 k, ID_valid, inst_id, ID_npc, imem_req, imem_addr, e.inst, e.npc, exp_pc);
      end
    end
  endtask

  task automatic test_redirect_hold();
    stall = 1'b1; imem_ready = 1'b1;
    tick();
    checks++;
    if ({imem_req, inst_id} !== {1'b0, word(32'hC)}) begin
      failures++;
      $display("FAIL hold_enter actual req=%b i=%h required req=0 i=%h", imem_req, inst_id, word(32'hC));
    end
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    checks++;
    if ({ID_valid, inst_id, ID_npc, imem_req, imem_addr} !== {1'b0, NOP_INST, 32'h0, 1'b1, 32'h100}) begin
      failures++;
      $display("FAIL redirect_hold actual v=%b i=%h n=%h req=%b a=%h required v=0 i=0 n=0 req=1 a=100",
               ID_valid, inst_id, ID_npc, imem_req, imem_addr);
    end
    redirect = 1'b0; stall = 1'b0;
    exp_pc = 32'h100;
    push_fetch();
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({ID_valid, inst_id, ID_npc} !== {1'b1, e.inst, e.npc}) begin
      failures++;
      $display("FAIL redirect_target actual v=%b i=%h n=%h required v=1 i=%h n=%h",
               ID_valid, inst_id, ID_npc, e.inst, e.npc);
    end
  endtask

  task automatic test_discard();
    imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
    for (int k = 0; k < 2; k++) begin
      tick();
      redirect = 1'b0;
      checks++;
      if ({ID_valid, inst_id, imem_req, imem_addr} !== {1'b0, NOP_INST, 1'b1, 32'h104}) begin
        failures++;
        $display("FAIL discard_wait_%0d actual v=%b i=%h req=%b a=%h required v=0 i=0 req=1 a=104",
                 k, ID_valid, inst_id, imem_req, imem_addr);
      end
    end
    imem_ready = 1'b1;
    tick();
    checks++;
    if ({ID_valid, inst_id, imem_addr} !== {1'b0, NOP_INST, 32'h40}) begin
      failures++;
      $display("FAIL discard_drop actual v=%b i=%h a=%h required v=0 i=0 a=40", ID_valid, inst_id, imem_addr);
    end
    exp_pc = 32'h40;
    push_fetch();
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({ID_valid, inst_id, ID_npc} !== {1'b1, e.inst, e.npc}) begin
      failures++;
      $display("FAIL discard_target actual v=%b i=%h n=%h required v=1 i=%h n=%h",
               ID_valid, inst_id, ID_npc, e.inst, e.npc);
    end
  endtask

  // A second redirect while discarding wins; low address bits are not masked.
  task automatic test_discard_overwrite();
    imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_pc = 32'h302;
    tick();
    redirect = 1'b0; imem_ready = 1'b1;
    tick();
    checks++;
    if ({ID_valid, imem_addr} !== {1'b0, 32'h302}) begin
      failures++;
      $display("FAIL discard_overwrite actual v=%b a=%h required v=0 a=302", ID_valid, imem_addr);
    end
    exp_pc = 32'h302;
    push_fetch();
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({ID_valid, inst_id, ID_npc} !== {1'b1, e.inst, e.npc}) begin
      failures++;
      $display("FAIL unaligned_target actual v=%b i=%h n=%h required v=1 i=%h n=%h",
               ID_valid, inst_id, ID_npc, e.inst, e.npc);
    end
  endtask

  task automatic test_rst_discard();
    imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h500;
    tick();
    checks++;
    if ({ID_valid, imem_addr} !== {1'b0, 32'h306}) begin
      failures++;
      $display("FAIL rst_pre_discard actual v=%b a=%h required v=0 a=306", ID_valid, imem_addr);
    end
    redirect = 1'b0; rst = 1'b1; imem_ready = 1'b1;
    tick();
    checks++;
    if ({ID_valid, inst_id, ID_npc, imem_req, imem_addr} !== {1'b0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL rst_in_discard actual v=%b i=%h n=%h req=%b a=%h required all zero",
               ID_valid, inst_id, ID_npc, imem_req, imem_addr);
    end
    rst = 1'b0;
    exp_pc = 32'h0;
    push_fetch();
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({ID_valid, inst_id, ID_npc, imem_addr} !== {1'b1, e.inst, e.npc, 32'h4}) begin
      failures++;
      $display("FAIL rst_refetch actual v=%b i=%h n=%h a=%h required v=1 i=%h n=%h a=4",
               ID_valid, inst_id, ID_npc, imem_addr, e.inst, e.npc);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_wrap();
    test_stall();
    test_redirect_hold();
    test_discard();
    test_discard_overwrite();
    test_rst_discard();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
